// File: rtl/m_trap_unit_if.sv
// Trap-unit bus: CSR access, retire/exception/mret events, interrupt lines and fetch redirect.
interface m_trap_unit_if #(
  parameter int NUM_LOCAL_IRQ = 16
);
  logic                     csr_en;
  logic [1:0]               csr_op;
  logic [11:0]              csr_addr;
  logic [31:0]              csr_wdata;
  logic [31:0]              csr_rdata;
  logic                     csr_illegal;
  logic                     exc_valid;
  logic [4:0]               exc_cause;
  logic [31:0]              exc_pc;
  logic [31:0]              exc_tval;
  logic                     mret;
  logic                     retire_valid;
  logic [31:0]              retire_next_pc;
  logic                     irq_msip;
  logic                     irq_mtip;
  logic                     irq_meip;
  logic [NUM_LOCAL_IRQ-1:0] irq_local;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic [1:0]               priv;
  logic                     irq_pending;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wdata,
    output exc_valid, exc_cause, exc_pc, exc_tval, mret,
    output retire_valid, retire_next_pc,
    output irq_msip, irq_mtip, irq_meip, irq_local,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, priv, irq_pending
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wdata,
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret,
    input  retire_valid, retire_next_pc,
    input  irq_msip, irq_mtip, irq_meip, irq_local,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc, priv, irq_pending
  );
endinterface

// File: rtl/m_trap_unit.sv
// M-mode trap/CSR controller: CSR reads are combinational, traps/mret commit at the edge and
// raise a registered one-cycle redirect; no backpressure, every event is accepted when presented.
module m_trap_unit #(
  parameter int          NUM_LOCAL_IRQ = 16,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input logic          clk,
  input logic          rst,
  m_trap_unit_if.slave bus
);

  localparam logic [1:0]  PRIV_M   = 2'b11;
  localparam logic [1:0]  PRIV_U   = 2'b00;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888 |
                                     (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [1:0]  mstatus_mpp_q, mstatus_mpp_d;
  logic [1:0]  priv_q, priv_d;
  logic [31:0] mie_reg_q, mie_reg_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] mip;
  logic [31:0] pend;
  logic [4:0]  irq_code;
  logic [31:0] csr_rdata;
  logic        csr_legal;
  logic        csr_is_write;
  logic        csr_illegal;
  logic [31:0] csr_nv;
  logic        take_exc, take_mret, take_irq, csr_wr;

  // Live interrupt view and fixed-priority pick: MEI > MSI > MTI > locals (lowest index wins).
  always_comb begin
    mip                       = '0;
    mip[3]                    = bus.irq_msip;
    mip[7]                    = bus.irq_mtip;
    mip[11]                   = bus.irq_meip;
    mip[16 +: NUM_LOCAL_IRQ]  = bus.irq_local;
    pend                      = mip & mie_reg_q;
    irq_code                  = 5'd0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (pend[16 + i]) irq_code = 5'(16 + i);
    end
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  always_comb begin
    csr_legal = 1'b1;
    csr_rdata = '0;
    case (bus.csr_addr)
      12'h300: csr_rdata = {19'b0, mstatus_mpp_q, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: csr_rdata = 32'h4010_0100;
      12'h304: csr_rdata = mie_reg_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip;
      12'hF14: csr_rdata = '0;
      default: csr_legal = 1'b0;
    endcase
    // Set/clear with a zero operand is a pure read, so it may target read-only CSRs.
    csr_is_write = (bus.csr_op == 2'b01) ||
                   ((bus.csr_op == 2'b10 || bus.csr_op == 2'b11) && bus.csr_wdata != 32'h0);
    csr_illegal  = bus.csr_en && (!csr_legal || priv_q == PRIV_U ||
                                  (csr_is_write && bus.csr_addr[11:10] == 2'b11));
    case (bus.csr_op)
      2'b01:   csr_nv = bus.csr_wdata;
      2'b10:   csr_nv = csr_rdata | bus.csr_wdata;
      2'b11:   csr_nv = csr_rdata & ~bus.csr_wdata;
      default: csr_nv = csr_rdata;
    endcase
  end

  always_comb begin
    take_exc  = bus.exc_valid;
    take_mret = !bus.exc_valid && bus.mret && priv_q == PRIV_M;
    take_irq  = !bus.exc_valid && !bus.mret && bus.retire_valid && !redirect_valid_q &&
                (priv_q == PRIV_U || mstatus_mie_q) && (|pend);
    csr_wr    = bus.csr_en && csr_is_write && !csr_illegal && !take_exc && !take_mret && !take_irq;
  end

  always_comb begin
    mstatus_mie_d    = mstatus_mie_q;
    mstatus_mpie_d   = mstatus_mpie_q;
    mstatus_mpp_d    = mstatus_mpp_q;
    priv_d           = priv_q;
    mie_reg_d        = mie_reg_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (csr_wr) begin
      case (bus.csr_addr)
        12'h300: begin
          mstatus_mie_d  = csr_nv[3];
          mstatus_mpie_d = csr_nv[7];
          // Only M and U exist, so any other MPP encoding collapses to U.
          mstatus_mpp_d  = (csr_nv[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
        end
        12'h304: mie_reg_d  = csr_nv & MIE_MASK;
        12'h305: mtvec_d    = {csr_nv[31:2], 1'b0, VECTORED_EN & csr_nv[0]};
        12'h340: mscratch_d = csr_nv;
        12'h341: mepc_d     = csr_nv & 32'hFFFF_FFFC;
        12'h342: mcause_d   = csr_nv;
        12'h343: mtval_d    = csr_nv;
        default: ;
      endcase
    end

    if (take_exc || take_irq) begin
      mepc_d           = (take_exc ? bus.exc_pc : bus.retire_next_pc) & 32'hFFFF_FFFC;
      mcause_d         = take_exc ? {27'b0, bus.exc_cause} : {1'b1, 26'b0, irq_code};
      mtval_d          = take_exc ? bus.exc_tval : 32'h0;
      mstatus_mpie_d   = mstatus_mie_q;
      mstatus_mie_d    = 1'b0;
      mstatus_mpp_d    = priv_q;
      priv_d           = PRIV_M;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = (take_irq && mtvec_q[0]) ?
                         {mtvec_q[31:2], 2'b00} + {25'b0, irq_code, 2'b00} :
                         {mtvec_q[31:2], 2'b00};
    end else if (take_mret) begin
      mstatus_mie_d    = mstatus_mpie_q;
      mstatus_mpie_d   = 1'b1;
      priv_d           = mstatus_mpp_q;
      mstatus_mpp_d    = PRIV_U;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mstatus_mpp_q    <= PRIV_M;
      priv_q           <= PRIV_M;
      mie_reg_q        <= '0;
      mtvec_q          <= MTVEC_RESET;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mstatus_mie_q    <= mstatus_mie_d;
      mstatus_mpie_q   <= mstatus_mpie_d;
      mstatus_mpp_q    <= mstatus_mpp_d;
      priv_q           <= priv_d;
      mie_reg_q        <= mie_reg_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.csr_rdata      = csr_rdata;
  assign bus.csr_illegal    = csr_illegal;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.priv           = priv_q;
  assign bus.irq_pending    = |pend;

endmodule

// File: tb/tb_m_trap_unit.sv
// Directed bench for m_trap_unit: stimulus queues expected CSR responses and redirect targets,
// negedge monitors pop and compare whenever the DUT presents a CSR response or a redirect.
module tb_m_trap_unit;

  logic clk;
  logic rst;
  logic probe;
  logic mon_en;
  int   n_chk;
  int   n_fail;

  m_trap_unit_if #(.NUM_LOCAL_IRQ(16)) bus ();

  m_trap_unit #(
    .NUM_LOCAL_IRQ(16),
    .MTVEC_RESET  (32'h0000_0000),
    .VECTORED_EN  (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        ill;
    logic        chk_priv;
    logic [1:0]  priv;
    logic        chk_irq;
    logic        irq;
    logic        chk_rdr;
  } exp_t;

  exp_t        cq[$];
  string       cn[$];
  logic [31:0] rq[$];
  exp_t        mon_e;
  string       mon_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
    n_chk++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, ev);
    end
  endtask

  // Redirect monitor: every pulse must match the next queued target.
  always @(negedge clk) begin
    if (mon_en && bus.redirect_valid) begin
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_redirect: got pc 0x%08h, expected no redirect", bus.redirect_pc);
      end else begin
        chk("redirect_pc", bus.redirect_pc, rq.pop_front());
      end
    end
  end

  // CSR/probe monitor.
  always @(negedge clk) begin
    if (mon_en && (bus.csr_en || probe)) begin
      if (cq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL csr_response: got a response, expected none queued");
      end else begin
        mon_e = cq.pop_front();
        mon_n = cn.pop_front();
        if (mon_e.mask != 32'h0)
          chk({mon_n, "/rdata"}, bus.csr_rdata & mon_e.mask, mon_e.rdata & mon_e.mask);
        chk({mon_n, "/illegal"}, {31'b0, bus.csr_illegal}, {31'b0, mon_e.ill});
        if (mon_e.chk_priv) chk({mon_n, "/priv"}, {30'b0, bus.priv}, {30'b0, mon_e.priv});
        if (mon_e.chk_irq)  chk({mon_n, "/irq_pending"}, {31'b0, bus.irq_pending}, {31'b0, mon_e.irq});
        if (mon_e.chk_rdr)  chk({mon_n, "/redirect"}, {bus.redirect_valid, bus.redirect_pc[30:0]}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] ev, input logic [31:0] mask, input logic ill,
                         input string nm);
    exp_t e;
    e = '{rdata: ev, mask: mask, ill: ill, default: '0};
    cq.push_back(e);
    cn.push_back(nm);
    bus.csr_en    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
    step();
    bus.csr_en    = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] ev, input string nm);
    csr_acc(2'b00, addr, 32'h0, ev, 32'hFFFF_FFFF, 1'b0, nm);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                    input string nm);
    csr_acc(op, addr, wd, 32'h0, 32'h0, 1'b0, nm);
  endtask

  task automatic prb(input logic cp, input logic [1:0] p, input logic ci, input logic i,
                     input logic cr, input string nm);
    exp_t e;
    e = '{chk_priv: cp, priv: p, chk_irq: ci, irq: i, chk_rdr: cr, default: '0};
    cq.push_back(e);
    cn.push_back(nm);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic exc(input logic [4:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                     input logic [31:0] tgt);
    rq.push_back(tgt);
    bus.exc_valid = 1'b1;
    bus.exc_cause = cause;
    bus.exc_pc    = pc;
    bus.exc_tval  = tval;
    step();
    bus.exc_valid = 1'b0;
  endtask

  task automatic do_mret(input logic [31:0] tgt);
    rq.push_back(tgt);
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
  endtask

  task automatic retire(input logic [31:0] npc, input logic taken, input logic [31:0] tgt);
    if (taken) rq.push_back(tgt);
    bus.retire_valid   = 1'b1;
    bus.retire_next_pc = npc;
    step();
    bus.retire_valid   = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; probe = 1'b0; mon_en = 1'b0; rst = 1'b1;
    bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.exc_valid = 1'b0; bus.exc_cause = '0; bus.exc_pc = '0; bus.exc_tval = '0;
    bus.mret = 1'b0; bus.retire_valid = 1'b0; bus.retire_next_pc = '0;
    bus.irq_msip = 1'b0; bus.irq_mtip = 1'b0; bus.irq_meip = 1'b0; bus.irq_local = '0;
    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state and CSR operations.
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    prb(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, "rst_state");
    rd(12'h305, 32'h0, "rst_mtvec");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h301, 32'h4010_0100, "misa");
    wr(2'b01, 12'h305, 32'h8000_0103, "wr_mtvec");
    rd(12'h305, 32'h8000_0101, "mtvec_mode_mask");
    wr(2'b10, 12'h304, 32'h0001_0888, "rs_mie");
    rd(12'h304, 32'h0001_0888, "mie_after_rs");
    wr(2'b11, 12'h304, 32'h0000_0008, "rc_mie");
    rd(12'h304, 32'h0001_0880, "mie_after_rc");
    wr(2'b01, 12'h304, 32'hFFFF_FFFF, "rw_mie_all");
    rd(12'h304, 32'hFFFF_0888, "mie_writable_mask");
    wr(2'b01, 12'h300, 32'h0000_0800, "rw_mstatus_mpp01");
    rd(12'h300, 32'h0000_0000, "mpp01_stores_u");
    csr_acc(2'b01, 12'h7C0, 32'h1, 32'h0, 32'h0, 1'b1, "ill_unmapped");
    csr_acc(2'b01, 12'hF14, 32'h1, 32'h0, 32'h0, 1'b1, "ill_ro_write");
    csr_acc(2'b10, 12'hF14, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "rs_zero_ro_read");
    wr(2'b01, 12'h301, 32'h0, "wr_misa");
    rd(12'h301, 32'h4010_0100, "misa_wr_ignored");
    wr(2'b01, 12'h344, 32'hFFFF_FFFF, "wr_mip");
    rd(12'h344, 32'h0, "mip_idle");

    // Synchronous exception.
    wr(2'b01, 12'h305, 32'h0000_0100, "mtvec_100");
    wr(2'b01, 12'h300, 32'h0000_1808, "mstatus_mie");
    exc(5'd2, 32'h40, 32'hDEAD, 32'h100);
    rd(12'h341, 32'h40, "exc_mepc");
    rd(12'h342, 32'h2, "exc_mcause");
    rd(12'h343, 32'hDEAD, "exc_mtval");
    rd(12'h300, 32'h0000_1880, "exc_mstatus");

    // Vectored interrupts and priority.
    wr(2'b01, 12'h305, 32'h0000_0201, "mtvec_vec");
    wr(2'b01, 12'h304, 32'h0001_0888, "mie_set");
    wr(2'b01, 12'h300, 32'h0000_1808, "mstatus_mie2");
    bus.irq_mtip = 1'b1; bus.irq_local[0] = 1'b1; bus.irq_meip = 1'b1;
    prb(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, "irq_pending_live");
    rd(12'h344, 32'h0001_0880, "mip_live");
    retire(32'h84, 1'b1, 32'h22C);
    rd(12'h342, 32'h8000_000B, "meip_mcause");
    rd(12'h341, 32'h84, "meip_mepc");
    rd(12'h343, 32'h0, "irq_mtval");
    rd(12'h300, 32'h0000_1880, "irq_mstatus");
    bus.irq_meip = 1'b0;
    do_mret(32'h84);
    retire(32'h90, 1'b0, 32'h0);
    retire(32'h94, 1'b1, 32'h21C);
    rd(12'h342, 32'h8000_0007, "mtip_mcause");
    rd(12'h341, 32'h94, "mtip_mepc");
    bus.irq_mtip = 1'b0;
    do_mret(32'h94);
    prb(1'b1, 2'b11, 1'b1, 1'b1, 1'b0, "mret_redirect_cycle");
    retire(32'hA0, 1'b1, 32'h240);
    rd(12'h342, 32'h8000_0010, "local0_mcause");
    bus.irq_local = '0;
    prb(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, "irq_cancelled");

    // Privilege round trip.
    wr(2'b01, 12'h340, 32'h0000_CAFE, "wr_mscratch");
    wr(2'b01, 12'h300, 32'h0000_0080, "mstatus_mpp_u");
    rd(12'h300, 32'h0000_0080, "mstatus_mpp_u_rd");
    wr(2'b01, 12'h341, 32'h0000_0300, "wr_mepc");
    do_mret(32'h300);
    prb(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, "priv_u");
    csr_acc(2'b01, 12'h340, 32'h1234, 32'h0, 32'h0, 1'b1, "u_mscratch_ill");
    csr_acc(2'b00, 12'h300, 32'h0, 32'h0, 32'h0, 1'b1, "u_read_ill");
    exc(5'd8, 32'h304, 32'h0, 32'h200);
    prb(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "exc_from_u_priv");
    rd(12'h300, 32'h0000_0080, "exc_from_u_mstatus");
    rd(12'h340, 32'h0000_CAFE, "mscratch_unchanged");
    rd(12'h342, 32'h8, "ecall_mcause");

    // Collisions: exception beats mret, interrupt and CSR write.
    wr(2'b01, 12'h300, 32'h0000_1808, "mstatus_mie3");
    wr(2'b01, 12'h341, 32'h0000_0400, "mepc_400");
    bus.irq_msip = 1'b1;
    prb(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, "msip_pending");
    cq.push_back('{rdata: 32'h0000_CAFE, mask: 32'hFFFF_FFFF, default: '0});
    cn.push_back("coll_csr");
    rq.push_back(32'h200);
    bus.exc_valid = 1'b1; bus.exc_cause = 5'd4; bus.exc_pc = 32'h48; bus.exc_tval = 32'h11;
    bus.mret = 1'b1; bus.retire_valid = 1'b1; bus.retire_next_pc = 32'h4C;
    bus.csr_en = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hBEEF;
    step();
    bus.exc_valid = 1'b0; bus.mret = 1'b0; bus.retire_valid = 1'b0; bus.csr_en = 1'b0;
    rd(12'h340, 32'h0000_CAFE, "coll_no_csr_write");
    rd(12'h342, 32'h4, "coll_mcause");
    rd(12'h341, 32'h48, "coll_mepc");
    do_mret(32'h48);
    retire(32'h60, 1'b0, 32'h0);
    retire(32'h64, 1'b1, 32'h20C);
    rd(12'h342, 32'h8000_0003, "msip_mcause");
    rd(12'h341, 32'h64, "msip_mepc");
    bus.irq_msip = 1'b0;

    // Reset during the redirect cycle.
    exc(5'd2, 32'h70, 32'h0, 32'h200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    prb(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, "midrst_state");
    rd(12'h300, 32'h0000_1800, "midrst_mstatus");
    rd(12'h305, 32'h0, "midrst_mtvec");
    rd(12'h304, 32'h0, "midrst_mie");
    rd(12'h341, 32'h0, "midrst_mepc");
    rd(12'h342, 32'h0, "midrst_mcause");
    rd(12'h343, 32'h0, "midrst_mtval");
    rd(12'h340, 32'h0, "midrst_mscratch");
    step();

    chk("redirects_outstanding", rq.size(), 32'd0);
    chk("csr_responses_outstanding", cq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
